operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch stage of the Simple RISC Machine datapath, directly upstream of the shifter/ALU.
//  - Holds the general register file: NREG x DATA_W, one write port, one combinational read port.
//  - On start, reads Rn into latch A, then Rm into latch B, over two consecutive cycles (single read port).
//  - Presents A/B with valid/ack handshake. b_out drives the shifter input; a_out drives the ALU A input.
// PARAMETERS
//  DATA_W  16  operand/register width
//  NREG    8   number of registers; IDX_W = $clog2(NREG) (3 at default)
//  BYPASS  1   1: a same-cycle write to the register being read is forwarded into the latch; 0: latch takes old value
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       synchronous, active-high reset
//  start     in   1       fetch request; accepted per BEHAVIOUR
//  rn        in   IDX_W   A-operand register index, captured on accept
//  rm        in   IDX_W   B-operand register index, captured on accept
//  write     in   1       register write enable
//  writenum  in   IDX_W   write index
//  data_in   in   DATA_W  write data
//  ack       in   1       downstream has consumed A/B
//  a_out     out  DATA_W  latched A operand
//  b_out     out  DATA_W  latched B operand (to shifter)
//  valid     out  1       a_out/b_out hold a completed fetch
//  busy      out  1       high in RD_A or RD_B
// BEHAVIOUR
//  Reset (sampled at clk edge while reset=1): all registers=0, a_out=b_out=0, state=IDLE, valid=0, busy=0.
//  - Reset dominates write and start; mid-fetch reset aborts to IDLE with no partial result.
//  States: IDLE, RD_A, RD_B, VALID. valid = (state==VALID); busy = (state==RD_A || state==RD_B).
//  IDLE:  start=1 -> capture rn_q<=rn, rm_q<=rm; go RD_A.
//  RD_A:  a_out <= R[rn_q] (bypassed per BYPASS); go RD_B. start ignored.
//  RD_B:  b_out <= R[rm_q] (bypassed per BYPASS); go VALID. start ignored.
//  VALID: ack=0 -> hold; a_out/b_out stable.
//         ack=1, start=0 -> IDLE.
//         ack=1, start=1 -> capture new indices; go RD_A (back-to-back fetch).
//         start without ack -> ignored.
//  Latency: start accepted at edge k -> a_out updates at k+1, b_out and valid at k+2.
//  a_out/b_out change only at the RD_A/RD_B edges; they hold their value in IDLE and after ack.
//  Write port: independent of FSM state; R[writenum] <= data_in at the edge when write=1.
//  Read-during-write (write=1 and writenum==read index, in RD_A or RD_B):
//  - BYPASS=1 -> latch gets data_in.
//  - BYPASS=0 -> latch gets the pre-write value.
//  - In both cases the register file is updated.
//  rn==rm is legal: both latches read the same register, each at its own read cycle.
//  All data paths are DATA_W wide; no arithmetic; indices are taken modulo NREG when NREG < 2**IDX_W is not used (NREG is a power of 2).
//  ack outside VALID is ignored.
// STRUCTURE
//  srm_pkg: DATA_W, NREG, IDX_W constants; typedef enum logic [1:0] {IDLE,RD_A,RD_B,VALID} fetch_state_t.
//  Sub-module regfile:
//  - NREG x DATA_W array, synchronous write, combinational read (readnum -> data_out), synchronous reset-to-zero.
//  - operand_fetch instantiates it and contains the FSM, index latches, bypass mux and A/B latches.
// TESTING
//  1. Write R3=16'h00F0, R5=16'h8001; start rn=3 rm=5 -> a_out=00F0 at k+1; b_out=8001, valid=1 at k+2; valid held until ack.
//  2. Back-to-back: in VALID drive ack=1, start=1 (rn=5, rm=3) -> no IDLE cycle; a_out=8001, b_out=00F0, valid=1 two edges later.
//  3. Hazard: in RD_B, write R5=16'h1234 -> BYPASS=1: b_out=1234; BYPASS=0: b_out=8001. Re-fetch gives 1234 in both builds.
//  4. Start pulsed in RD_A, RD_B, and in VALID without ack -> ignored; indices and outputs unchanged.
//  5. Reset asserted in RD_B -> next edge: state IDLE, valid=0, busy=0, a_out=b_out=0; fetch of R3 then returns 0000.
//  6. rn=rm=7, R7=16'hFFFF -> a_out=b_out=FFFF; ack with start=0 -> IDLE, outputs hold FFFF.

Source files
------------

// File: rtl/srm_pkg.sv
// srm_pkg: shared datapath constants and fetch FSM states for the Simple RISC Machine
package srm_pkg;
    localparam int DATA_W = 16;
    localparam int NREG = 8;
    localparam int IDX_W = $clog2(NREG);
    typedef enum logic [1:0] {IDLE, RD_A, RD_B, VALID} fetch_state_t;
endpackage

// File: rtl/regfile.sv
// regfile: NREG x DATA_W register file, synchronous write and reset, combinational read
module regfile #(
    parameter int DATA_W = 16,
    parameter int NREG = 8,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [IDX_W-1:0]  writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]  readnum,
    output logic [DATA_W-1:0] data_out
);
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    assign data_out = regs[readnum];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads Rn then Rm through a single read port into A/B latches with valid/ack handshake
module operand_fetch
    import srm_pkg::*;
#(
    parameter int DATA_W = srm_pkg::DATA_W,
    parameter int NREG = srm_pkg::NREG,
    parameter int BYPASS = 1,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  rn,
    input  logic [IDX_W-1:0]  rm,
    input  logic              write,
    input  logic [IDX_W-1:0]  writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ack,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid,
    output logic              busy
);
    fetch_state_t state;
    logic [IDX_W-1:0] rn_q, rm_q, read_idx;
    logic [DATA_W-1:0] rf_data, rd_data;

    regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum),
        .data_in(data_in), .readnum(read_idx), .data_out(rf_data)
    );

    // The read port serves rn_q in RD_A and rm_q otherwise; a same-edge write may be forwarded
    assign read_idx = (state == RD_A) ? rn_q : rm_q;
    assign rd_data = (BYPASS != 0 && write && writenum == read_idx) ? data_in : rf_data;
    assign valid = (state == VALID);
    assign busy = (state == RD_A) || (state == RD_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_out <= '0;
            b_out <= '0;
            rn_q <= '0;
            rm_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rn_q <= rn;
                    rm_q <= rm;
                    state <= RD_A;
                end
                RD_A: begin
                    a_out <= rd_data;
                    state <= RD_B;
                end
                RD_B: begin
                    b_out <= rd_data;
                    state <= VALID;
                end
                VALID: if (ack) begin
                    if (start) begin
                        rn_q <= rn;
                        rm_q <= rm;
                    end
                    state <= start ? RD_A : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vectors with hand-computed expectations for operand_fetch
module tb_operand_fetch;
    localparam int BYPASS = 1;
    logic clk = 0, reset = 1, start = 0, write = 0, ack = 0;
    logic [2:0] rn = 0, rm = 0, writenum = 0;
    logic [15:0] data_in = 0, a_out, b_out;
    logic valid, busy;
    int n_cmp = 0, n_bad = 0;

    operand_fetch #(.DATA_W(16), .NREG(8), .BYPASS(BYPASS)) dut (
        .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .write(write),
        .writenum(writenum), .data_in(data_in), .ack(ack), .a_out(a_out),
        .b_out(b_out), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic v, input logic b, input logic [15:0] a, input logic [15:0] bb);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".a"}, 32'(a_out), 32'(a));
        chk({tag, ".b"}, 32'(b_out), 32'(bb));
    endtask

    initial begin
        tick(); tick();
        reset = 0;
        chk_st("reset", 0, 0, 16'h0000, 16'h0000);
        // 1: basic fetch with latency check
        write = 1; writenum = 3; data_in = 16'h00F0; tick();
        writenum = 5; data_in = 16'h8001; tick();
        write = 0; start = 1; rn = 3; rm = 5; tick();
        start = 0;
        chk_st("t1_k", 0, 1, 16'h0000, 16'h0000);
        tick(); chk_st("t1_k1", 0, 1, 16'h00F0, 16'h0000);
        tick(); chk_st("t1_k2", 1, 0, 16'h00F0, 16'h8001);
        tick(); tick(); chk_st("t1_hold", 1, 0, 16'h00F0, 16'h8001);
        // 2: back-to-back fetch with swapped indices
        ack = 1; start = 1; rn = 5; rm = 3; tick();
        ack = 0; start = 0;
        chk_st("t2_k", 0, 1, 16'h00F0, 16'h8001);
        tick(); chk_st("t2_k1", 0, 1, 16'h8001, 16'h8001);
        tick(); chk_st("t2_k2", 1, 0, 16'h8001, 16'h00F0);
        // 3: write to rm during RD_B
        ack = 1; start = 1; rn = 3; rm = 5; tick();
        ack = 0; start = 0; tick();
        chk_st("t3_rdb", 0, 1, 16'h00F0, 16'h00F0);
        write = 1; writenum = 5; data_in = 16'h1234; tick();
        write = 0;
        chk_st("t3_haz", 1, 0, 16'h00F0, BYPASS ? 16'h1234 : 16'h8001);
        ack = 1; start = 1; rn = 5; rm = 5; tick();
        ack = 0; start = 0; tick(); tick();
        chk_st("t3_refetch", 1, 0, 16'h1234, 16'h1234);
        // 4: start ignored outside IDLE / ack-qualified VALID
        start = 1; rn = 0; rm = 0; tick();
        chk_st("t4_noack", 1, 0, 16'h1234, 16'h1234);
        start = 0; ack = 1; tick();
        chk_st("t4_idle", 0, 0, 16'h1234, 16'h1234);
        ack = 0; start = 1; rn = 3; rm = 5; tick();
        rn = 0; rm = 0; tick();
        chk_st("t4_rda", 0, 1, 16'h00F0, 16'h1234);
        tick();
        chk_st("t4_rdb", 1, 0, 16'h00F0, 16'h1234);
        start = 0;
        // 5: reset during RD_B
        ack = 1; start = 1; rn = 3; rm = 5; tick();
        ack = 0; start = 0; tick();
        reset = 1; tick();
        reset = 0;
        chk_st("t5_rst", 0, 0, 16'h0000, 16'h0000);
        start = 1; rn = 3; rm = 3; tick();
        start = 0; tick(); tick();
        chk_st("t5_r3", 1, 0, 16'h0000, 16'h0000);
        // 6: rn == rm, then ack to IDLE
        ack = 1; write = 1; writenum = 7; data_in = 16'hFFFF; tick();
        ack = 0; write = 0; start = 1; rn = 7; rm = 7; tick();
        start = 0; tick(); tick();
        chk_st("t6_same", 1, 0, 16'hFFFF, 16'hFFFF);
        ack = 1; tick();
        ack = 0;
        chk_st("t6_idle", 0, 0, 16'hFFFF, 16'hFFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
